// File: rtl/adder_arb_defs.sv
// Shared definitions for the round-robin arbiter in front of the shared 32-bit adder.
package adder_arb_defs;

  localparam int unsigned WIDTH = 32;

  // 2'd3 is unused; the FSM treats it as a fault and returns to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/adder32.sv
// Shared 32-bit adder: sum and carry-out of two unsigned operands.
module adder32
  import adder_arb_defs::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  assign {c, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder32_arbiter.sv
// Round-robin arbiter sharing one adder32 among NREQ requesters; one op in flight,
// response held on a single valid/ready port until consumed.
module adder32_arbiter
  import adder_arb_defs::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_s,
  output logic                  rsp_c,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_s_q;
  logic             rsp_c_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             busy_q;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   grant_id;
  logic             grant_found;
  logic [WIDTH-1:0] sum;
  logic             carry;

  for (genvar i = 0; i < int'(NREQ); i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  adder32 u_adder32 (
    .a (a_q),
    .b (b_q),
    .s (sum),
    .c (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_s_q     <= '0;
      rsp_c_q     <= 1'b0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            a_q      <= a_arr[grant_id];
            b_q      <= b_arr[grant_id];
            id_q     <= grant_id;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_s_q     <= sum;
          rsp_c_q     <= carry;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;

endmodule
